// File: rtl/neurosync_play_feedback.sv
// Responder side of the play handshake: judges the player's answer and plays
// a buzzer beep pattern (double high beep = correct, single low beep = wrong),
// then pulses pronto_play and holds acertou_play for the game controller.
//
// state  | meaning
// OCIOSO | idle, waiting for a play request
// TOCA   | beep in progress, buzzer toggling at the selected tone
// PAUSA  | silent gap between beeps
// PRONTO | one-cycle done pulse back to the controller
module neurosync_play_feedback #(
  parameter int unsigned DIV_OK    = 4,
  parameter int unsigned DIV_ERR   = 8,
  parameter int unsigned BEEP_LEN  = 32,
  parameter int unsigned GAP_LEN   = 16,
  parameter int unsigned BEEPS_OK  = 2,
  parameter int unsigned BEEPS_ERR = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       play,
  input  logic       cancela,
  input  logic       modo_resposta,
  input  logic [1:0] resposta,
  input  logic [1:0] esperado,
  output logic       buzzer,
  output logic       tocando,
  output logic       pronto_play,
  output logic       acertou_play
);

  typedef enum logic [1:0] {OCIOSO, TOCA, PAUSA, PRONTO} state_t;

  // Counters reload with length-1 and run down to zero.
  localparam logic [15:0] DIV_OK_M1  = 16'(DIV_OK - 1);
  localparam logic [15:0] DIV_ERR_M1 = 16'(DIV_ERR - 1);
  localparam logic [15:0] BEEP_M1    = 16'(BEEP_LEN - 1);
  localparam logic [15:0] GAP_M1     = 16'(GAP_LEN - 1);
  localparam logic [15:0] N_OK       = 16'(BEEPS_OK);
  localparam logic [15:0] N_ERR      = 16'(BEEPS_ERR);

  state_t      state, state_nxt;
  logic [15:0] cnt;
  logic [15:0] tone_cnt;
  logic [15:0] div_sel;
  logic [15:0] beeps_left;
  logic        acerto_in;
  logic [15:0] div_in;
  logic [15:0] n_in;
  logic        start;

  // Judge the incoming request; confirmation mode always counts as correct.
  always_comb begin
    acerto_in = !modo_resposta || (resposta == esperado);
    div_in    = acerto_in ? DIV_OK_M1 : DIV_ERR_M1;
    n_in      = !modo_resposta ? 16'd1 : (acerto_in ? N_OK : N_ERR);
    start     = (state == OCIOSO) && play && !cancela;
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= OCIOSO;
    else        state <= state_nxt;
  end

  // Next-state logic; cancela overrides everything and returns to idle.
  always_comb begin
    state_nxt = state;
    case (state)
      OCIOSO: if (play) state_nxt = TOCA;
      TOCA:   if (cnt == 16'd0) state_nxt = (beeps_left == 16'd1) ? PRONTO : PAUSA;
      PAUSA:  if (cnt == 16'd0) state_nxt = TOCA;
      PRONTO: state_nxt = OCIOSO;
      default: state_nxt = OCIOSO;
    endcase
    if (cancela) state_nxt = OCIOSO;
  end

  // Phase/tone counters, registered buzzer and held result.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt          <= '0;
      tone_cnt     <= '0;
      div_sel      <= '0;
      beeps_left   <= '0;
      buzzer       <= 1'b0;
      acertou_play <= 1'b0;
    end else begin
      case (state)
        OCIOSO: begin
          buzzer <= 1'b0;
          if (start) begin
            acertou_play <= acerto_in;
            div_sel      <= div_in;
            beeps_left   <= n_in;
            cnt          <= BEEP_M1;
            tone_cnt     <= div_in;
            buzzer       <= 1'b1;
          end
        end
        TOCA: begin
          if (cnt == 16'd0) begin
            buzzer     <= 1'b0;
            beeps_left <= beeps_left - 16'd1;
            cnt        <= GAP_M1;
          end else begin
            cnt <= cnt - 16'd1;
            if (tone_cnt == 16'd0) begin
              buzzer   <= ~buzzer;
              tone_cnt <= div_sel;
            end else begin
              tone_cnt <= tone_cnt - 16'd1;
            end
          end
        end
        PAUSA: begin
          buzzer <= 1'b0;
          if (cnt == 16'd0) begin
            cnt      <= BEEP_M1;
            tone_cnt <= div_sel;
            buzzer   <= 1'b1;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: buzzer <= 1'b0;
      endcase
      if (cancela) buzzer <= 1'b0;
    end
  end

  // Status outputs decode straight from the state register.
  always_comb begin
    tocando     = (state == TOCA) || (state == PAUSA);
    pronto_play = (state == PRONTO);
  end

endmodule

// File: tb/tb_neurosync_play_feedback.sv
module tb_neurosync_play_feedback;

  localparam int BL = 32;
  localparam int GL = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       play = 1'b0;
  logic       cancela = 1'b0;
  logic       modo_resposta = 1'b0;
  logic [1:0] resposta = 2'b00;
  logic [1:0] esperado = 2'b00;
  logic       buzzer, tocando, pronto_play, acertou_play;

  int compared = 0;
  int mismatched = 0;

  logic [2:0] exp_q[$];
  logic       exp_ac_q[$];

  neurosync_play_feedback dut (
    .clock(clock), .reset(reset), .play(play), .cancela(cancela),
    .modo_resposta(modo_resposta), .resposta(resposta), .esperado(esperado),
    .buzzer(buzzer), .tocando(tocando), .pronto_play(pronto_play),
    .acertou_play(acertou_play)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Expected {buzzer,tocando,pronto} per cycle after E0, built from the pattern definition.
  task automatic push_pattern(input logic ac, input logic modo);
    int div, n, total, p;
    logic b;
    div = ac ? 4 : 8;
    n = !modo ? 1 : (ac ? 2 : 1);
    total = n * BL + (n - 1) * GL;
    for (int k = 0; k < total; k++) begin
      p = k % (BL + GL);
      b = (p < BL) ? (((p / div) % 2) == 0) : 1'b0;
      exp_q.push_back({b, 1'b1, 1'b0});
    end
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b000);
    exp_ac_q.push_back(ac);
  endtask

  task automatic run_pattern(input logic modo, input logic [1:0] r, input logic [1:0] e,
                             input int intrude);
    logic ac, exp_ac;
    logic [2:0] ev;
    int k;
    ac = !modo || (r == e);
    push_pattern(ac, modo);
    modo_resposta = modo; resposta = r; esperado = e; play = 1'b1;
    tick;
    play = 1'b0;
    exp_ac = exp_ac_q.pop_front();
    k = 0;
    while (exp_q.size() > 0) begin
      ev = exp_q.pop_front();
      check($sformatf("pattern_c%0d", k), {buzzer, tocando, pronto_play}, ev);
      if (k == 0 || ev[0]) check($sformatf("acertou_c%0d", k), acertou_play, exp_ac);
      if (k == intrude) begin
        play = 1'b1; modo_resposta = 1'b1; resposta = r ^ 2'b01; esperado = e;
      end
      tick;
      play = 1'b0;
      k++;
    end
  endtask

  initial begin
    logic seen;
    // 1: reset and idle
    repeat (3) tick;
    check("rst_outputs", {buzzer, tocando, pronto_play, acertou_play}, 4'b0000);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      check("idle_outputs", {buzzer, tocando, pronto_play, acertou_play}, 4'b0000);
    end
    // 2: correct answer, two high beeps
    run_pattern(1'b1, 2'b10, 2'b10, -1);
    // 3: wrong answer, one low beep; play during PRONTO ignored
    run_pattern(1'b1, 2'b01, 2'b10, 32);
    // 4: confirmation mode
    run_pattern(1'b0, 2'b00, 2'b11, -1);
    // 5a: second play during TOCA ignored
    run_pattern(1'b1, 2'b10, 2'b10, 10);
    // 5b: cancela during PAUSA
    modo_resposta = 1'b1; resposta = 2'b10; esperado = 2'b10; play = 1'b1;
    tick;
    play = 1'b0;
    check("cancel_acertou_set", acertou_play, 1'b1);
    repeat (40) tick;
    check("cancel_in_pausa", {buzzer, tocando}, 2'b01);
    cancela = 1'b1;
    tick;
    cancela = 1'b0;
    check("cancel_outputs", {buzzer, tocando}, 2'b00);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick;
      if (pronto_play !== 1'b0 || tocando !== 1'b0) seen = 1'b1;
    end
    check("cancel_no_pronto", seen, 1'b0);
    check("cancel_acertou_kept", acertou_play, 1'b1);
    // 5c: cancela and play together -> request dropped
    resposta = 2'b01; cancela = 1'b1; play = 1'b1;
    tick;
    cancela = 1'b0; play = 1'b0;
    check("cancel_play_dropped", {buzzer, tocando, acertou_play}, 3'b001);
    tick;
    check("cancel_play_idle", {buzzer, tocando, pronto_play}, 3'b000);
    // 6: reset mid-TOCA
    resposta = 2'b11; esperado = 2'b11; play = 1'b1;
    tick;
    play = 1'b0;
    repeat (5) tick;
    check("pre_reset_tocando", tocando, 1'b1);
    reset = 1'b0;
    #1;
    check("async_reset_outputs", {buzzer, tocando, pronto_play, acertou_play}, 4'b0000);
    tick;
    tick;
    reset = 1'b1;
    tick;
    run_pattern(1'b1, 2'b11, 2'b11, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
